seq_gen: RTL

Parametrised multi-mode state-sequence generator, the successor to the team's fixed 3-bit next-state sequencer. Steps a WIDTH-bit state register through one of five sequences (binary up, binary down, Gray, Johnson, maximal LFSR) and supports parallel load, deferred mode switching at sequence wrap, a terminal-step pulse and a registered compare output `y`. Used as a pattern and timebase source feeding the Activity datapaths and the display/LED test logic.

---
 rtl/seq_gen_pkg.sv | 53 +++++
 rtl/seq_gen_if.sv | 30 +++
 rtl/seq_next.sv | 48 ++++
 rtl/seq_gen.sv | 92 +++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and constant helpers for the multi-mode sequence generator.
//   seq_mode_e : sequence mode encoding (5..7 reserved)
//   lfsr_taps  : maximal Fibonacci tap mask for widths 3..16 (bit n-1 = tap n)
//   start_val  : first/wrap value of each mode
//   gray2bin   : Gray-to-binary conversion used when loading in Gray mode
package seq_gen_pkg;

  localparam int unsigned MAX_WIDTH = 16;

  typedef enum logic [2:0] {
    SEQ_BIN_UP   = 3'd0,
    SEQ_BIN_DOWN = 3'd1,
    SEQ_GRAY     = 3'd2,
    SEQ_JOHNSON  = 3'd3,
    SEQ_LFSR     = 3'd4
  } seq_mode_e;

  function automatic logic [MAX_WIDTH-1:0] lfsr_taps(int unsigned width);
    case (width)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [MAX_WIDTH-1:0] start_val(seq_mode_e mode, int unsigned width);
    case (mode)
      SEQ_BIN_DOWN: return 16'((32'd1 << width) - 32'd1);
      SEQ_LFSR:     return 16'd1;
      default:      return 16'd0;
    endcase
  endfunction

  function automatic logic [MAX_WIDTH-1:0] gray2bin(logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/seq_gen_if.sv
// Control/status bundle of seq_gen.
//   master: drives en, load, load_val, mode_wr, mode_in, match_val
//   slave : drives q, mode, pend, term, y
interface seq_gen_if
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             mode_wr;
  logic [2:0]       mode_in;
  logic [WIDTH-1:0] match_val;
  logic [WIDTH-1:0] q;
  seq_mode_e        mode;
  logic             pend;
  logic             term;
  logic             y;

  modport master (
    output en, load, load_val, mode_wr, mode_in, match_val,
    input  q, mode, pend, term, y
  );

  modport slave (
    input  en, load, load_val, mode_wr, mode_in, match_val,
    output q, mode, pend, term, y
  );
endinterface

// File: rtl/seq_next.sv
// Combinational one-step successor of {mode, q, b} with wrap detect.
//   mode/q/b : active mode, current state, internal Gray binary counter
//   q_nxt    : next state, b_nxt: next Gray counter
//   wrap     : q_nxt equals the start value of the active mode
module seq_next
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  seq_mode_e        mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             wrap
);
  localparam int unsigned     TW   = WIDTH - 1;
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic [TW-1:0]    trans;
  logic [WIDTH-1:0] b_inc;

  always_comb begin
    q_nxt = q;
    b_nxt = b;
    b_inc = b + WIDTH'(1);
    // a Johnson code has at most one transition between adjacent bits
    trans = q[WIDTH-1:1] ^ q[WIDTH-2:0];
    case (mode)
      SEQ_BIN_UP:   q_nxt = q + WIDTH'(1);
      SEQ_BIN_DOWN: q_nxt = q - WIDTH'(1);
      SEQ_GRAY: begin
        b_nxt = b_inc;
        q_nxt = b_inc ^ (b_inc >> 1);
      end
      SEQ_JOHNSON: begin
        if ((trans & (trans - TW'(1))) == '0) q_nxt = {q[WIDTH-2:0], ~q[WIDTH-1]};
        else                                  q_nxt = '0;
      end
      SEQ_LFSR: begin
        if (q == '0) q_nxt = WIDTH'(1);
        else         q_nxt = {q[WIDTH-2:0], ^(q & TAPS)};
      end
      default: q_nxt = q;
    endcase
    wrap = (q_nxt == WIDTH'(start_val(mode, WIDTH)));
  end
endmodule

// File: rtl/seq_gen.sv
// Multi-mode state-sequence generator (binary up/down, Gray, Johnson, LFSR)
// with parallel load, deferred mode switching at wrap and a compare flag.
//   clk, reset (async, active-low)
//   bus.slave : en/load/load_val/mode_wr/mode_in/match_val in,
//               q/mode/pend/term/y out (all registered)
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter seq_mode_e   RESET_MODE = SEQ_BIN_UP
) (
  input logic      clk,
  input logic      reset,
  seq_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(start_val(RESET_MODE, WIDTH));

  logic [WIDTH-1:0] q_r, q_n, b_r, b_n, step_q, step_b;
  seq_mode_e        mode_r, mode_n, pend_mode_r, pend_mode_n, req_mode;
  logic             pend_r, pend_n, req_pend, wr_ok;
  logic             term_r, term_n, y_r, y_n, step_wrap;

  seq_next #(.WIDTH(WIDTH)) u_next (
    .mode  (mode_r),
    .q     (q_r),
    .b     (b_r),
    .q_nxt (step_q),
    .b_nxt (step_b),
    .wrap  (step_wrap)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r         <= RST_Q;
      b_r         <= '0;
      mode_r      <= RESET_MODE;
      pend_mode_r <= RESET_MODE;
      pend_r      <= 1'b0;
      term_r      <= 1'b0;
      y_r         <= 1'b0;
    end else begin
      q_r         <= q_n;
      b_r         <= b_n;
      mode_r      <= mode_n;
      pend_mode_r <= pend_mode_n;
      pend_r      <= pend_n;
      term_r      <= term_n;
      y_r         <= y_n;
    end
  end

  // Next state: load > step > hold; an incoming write bypasses the pending register
  always_comb begin
    wr_ok       = bus.mode_wr && (bus.mode_in <= 3'(SEQ_LFSR));
    req_mode    = wr_ok ? seq_mode_e'(bus.mode_in) : pend_mode_r;
    req_pend    = pend_r || wr_ok;
    q_n         = q_r;
    b_n         = b_r;
    mode_n      = mode_r;
    pend_mode_n = req_mode;
    pend_n      = req_pend;
    term_n      = 1'b0;
    if (bus.load) begin
      if (req_pend) begin
        mode_n = req_mode;
        pend_n = 1'b0;
      end
      q_n = bus.load_val;
      // only meaningful in Gray mode: keeps stepping continuous from q
      b_n = WIDTH'(gray2bin(16'(bus.load_val)));
    end else if (bus.en) begin
      term_n = step_wrap;
      if (step_wrap && req_pend) begin
        mode_n = req_mode;
        pend_n = 1'b0;
        q_n    = WIDTH'(start_val(req_mode, WIDTH));
        b_n    = '0;
      end else begin
        q_n = step_q;
        b_n = step_b;
      end
    end
    y_n = (q_n == bus.match_val);
  end

  assign bus.q    = q_r;
  assign bus.mode = mode_r;
  assign bus.pend = pend_r;
  assign bus.term = term_r;
  assign bus.y    = y_r;
endmodule
